// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: runs one TLBSRCH/RD/WR/FILL/INVTLB at a time through
// IDLE -> EXEC -> RESP, strobing the TLB in EXEC and returning registered CSR updates.
module tlb_ctrl #(
  parameter  int TLBENTRY = 16,
  localparam int IW       = $clog2(TLBENTRY)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [4:0]    req_inv_op,
  input  logic [9:0]    req_inv_asid,
  input  logic [31:0]   req_inv_va,
  input  logic [IW-1:0] csr_idx,
  input  logic [5:0]    csr_ps,
  input  logic          csr_ne,
  input  logic [18:0]   csr_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [27:0]   csr_elo0,
  input  logic [27:0]   csr_elo1,
  input  logic          csr_refill,
  output logic [19:0]   tlb_s_vpn,
  output logic [9:0]    tlb_s_asid,
  input  logic          tlb_s_hit,
  input  logic [IW-1:0] tlb_s_idx,
  output logic [IW-1:0] tlb_r_idx,
  input  logic [18:0]   tlb_r_vppn,
  input  logic [9:0]    tlb_r_asid,
  input  logic [5:0]    tlb_r_ps,
  input  logic          tlb_r_e,
  input  logic [27:0]   tlb_r_elo0,
  input  logic [27:0]   tlb_r_elo1,
  output logic          tlb_w_en,
  output logic [IW-1:0] tlb_w_idx,
  output logic [18:0]   tlb_w_vppn,
  output logic [5:0]    tlb_w_ps,
  output logic [9:0]    tlb_w_asid,
  output logic          tlb_w_e,
  output logic [27:0]   tlb_w_elo0,
  output logic [27:0]   tlb_w_elo1,
  output logic          tlb_inv_en,
  output logic [4:0]    tlb_inv_op,
  output logic [9:0]    tlb_inv_asid,
  output logic [18:0]   tlb_inv_vppn,
  output logic          resp_valid,
  output logic [2:0]    resp_op,
  output logic          resp_ine,
  output logic          resp_ne,
  output logic [IW-1:0] resp_idx,
  output logic [5:0]    resp_ps,
  output logic [18:0]   resp_vppn,
  output logic [9:0]    resp_asid,
  output logic          resp_e,
  output logic [27:0]   resp_elo0,
  output logic [27:0]   resp_elo1
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    inv_op_q, inv_op_d;
  logic [9:0]    inv_asid_q, inv_asid_d;
  logic [18:0]   inv_vppn_q, inv_vppn_d;
  logic [IW-1:0] fill_ptr_q, fill_ptr_d;
  logic          resp_valid_q, resp_valid_d;
  logic [2:0]    resp_op_q, resp_op_d;
  logic          resp_ine_q, resp_ine_d;
  logic          resp_ne_q, resp_ne_d;
  logic [IW-1:0] resp_idx_q, resp_idx_d;
  logic [5:0]    resp_ps_q, resp_ps_d;
  logic [18:0]   resp_vppn_q, resp_vppn_d;
  logic [9:0]    resp_asid_q, resp_asid_d;
  logic          resp_e_q, resp_e_d;
  logic [27:0]   resp_elo0_q, resp_elo0_d;
  logic [27:0]   resp_elo1_q, resp_elo1_d;

  logic exec_live;
  logic is_write;
  logic inv_legal;
  logic unused_va;

  // Reset gates the strobes combinationally so a reset landing in EXEC never writes.
  assign exec_live = (state_q == EXEC) && !reset;
  assign is_write  = (op_q == OP_WR) || (op_q == OP_FILL);
  assign inv_legal = (inv_op_q <= 5'd6);
  assign unused_va = ^req_inv_va[12:0];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    inv_op_d     = inv_op_q;
    inv_asid_d   = inv_asid_q;
    inv_vppn_d   = inv_vppn_q;
    fill_ptr_d   = fill_ptr_q;
    resp_valid_d = 1'b0;
    resp_op_d    = resp_op_q;
    resp_ine_d   = resp_ine_q;
    resp_ne_d    = resp_ne_q;
    resp_idx_d   = resp_idx_q;
    resp_ps_d    = resp_ps_q;
    resp_vppn_d  = resp_vppn_q;
    resp_asid_d  = resp_asid_q;
    resp_e_d     = resp_e_q;
    resp_elo0_d  = resp_elo0_q;
    resp_elo1_d  = resp_elo1_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = EXEC;
          op_d       = req_op;
          inv_op_d   = req_inv_op;
          inv_asid_d = req_inv_asid;
          inv_vppn_d = req_inv_va[31:13];
        end
      end
      EXEC: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_op_d    = op_q;
        resp_ine_d   = 1'b0;
        case (op_q)
          OP_SRCH: begin
            resp_ne_d  = !tlb_s_hit;
            resp_idx_d = tlb_s_hit ? tlb_s_idx : csr_idx;
          end
          OP_RD: begin
            resp_ne_d   = !tlb_r_e;
            resp_e_d    = tlb_r_e;
            resp_ps_d   = tlb_r_e ? tlb_r_ps   : '0;
            resp_vppn_d = tlb_r_e ? tlb_r_vppn : '0;
            resp_asid_d = tlb_r_e ? tlb_r_asid : '0;
            resp_elo0_d = tlb_r_e ? tlb_r_elo0 : '0;
            resp_elo1_d = tlb_r_e ? tlb_r_elo1 : '0;
          end
          OP_WR: ;
          OP_FILL: fill_ptr_d = fill_ptr_q + 1'b1;
          OP_INV:  resp_ine_d = !inv_legal;
          default: resp_ine_d = 1'b1;
        endcase
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      inv_op_q     <= '0;
      inv_asid_q   <= '0;
      inv_vppn_q   <= '0;
      fill_ptr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= '0;
      resp_ine_q   <= 1'b0;
      resp_ne_q    <= 1'b0;
      resp_idx_q   <= '0;
      resp_ps_q    <= '0;
      resp_vppn_q  <= '0;
      resp_asid_q  <= '0;
      resp_e_q     <= 1'b0;
      resp_elo0_q  <= '0;
      resp_elo1_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      inv_op_q     <= inv_op_d;
      inv_asid_q   <= inv_asid_d;
      inv_vppn_q   <= inv_vppn_d;
      fill_ptr_q   <= fill_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_op_q    <= resp_op_d;
      resp_ine_q   <= resp_ine_d;
      resp_ne_q    <= resp_ne_d;
      resp_idx_q   <= resp_idx_d;
      resp_ps_q    <= resp_ps_d;
      resp_vppn_q  <= resp_vppn_d;
      resp_asid_q  <= resp_asid_d;
      resp_e_q     <= resp_e_d;
      resp_elo0_q  <= resp_elo0_d;
      resp_elo1_q  <= resp_elo1_d;
    end
  end

  assign req_ready    = (state_q == IDLE);

  assign tlb_s_vpn    = {csr_vppn, 1'b0};
  assign tlb_s_asid   = csr_asid;
  assign tlb_r_idx    = csr_idx;

  assign tlb_w_en     = exec_live && is_write;
  assign tlb_w_idx    = (op_q == OP_FILL) ? fill_ptr_q : csr_idx;
  assign tlb_w_vppn   = csr_vppn;
  assign tlb_w_ps     = csr_ps;
  assign tlb_w_asid   = csr_asid;
  assign tlb_w_e      = csr_refill || !csr_ne;
  assign tlb_w_elo0   = csr_elo0;
  assign tlb_w_elo1   = csr_elo1;

  assign tlb_inv_en   = exec_live && (op_q == OP_INV) && inv_legal;
  assign tlb_inv_op   = inv_op_q;
  assign tlb_inv_asid = inv_asid_q;
  assign tlb_inv_vppn = inv_vppn_q;

  assign resp_valid   = resp_valid_q;
  assign resp_op      = resp_op_q;
  assign resp_ine     = resp_ine_q;
  assign resp_ne      = resp_ne_q;
  assign resp_idx     = resp_idx_q;
  assign resp_ps      = resp_ps_q;
  assign resp_vppn    = resp_vppn_q;
  assign resp_asid    = resp_asid_q;
  assign resp_e       = resp_e_q;
  assign resp_elo0    = resp_elo0_q;
  assign resp_elo1    = resp_elo1_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: each op is walked through EXEC and RESP with fixed expectations.
module tb_tlb_ctrl;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [4:0]    req_inv_op;
  logic [9:0]    req_inv_asid;
  logic [31:0]   req_inv_va;
  logic [IW-1:0] csr_idx;
  logic [5:0]    csr_ps;
  logic          csr_ne;
  logic [18:0]   csr_vppn;
  logic [9:0]    csr_asid;
  logic [27:0]   csr_elo0, csr_elo1;
  logic          csr_refill;
  logic [19:0]   tlb_s_vpn;
  logic [9:0]    tlb_s_asid;
  logic          tlb_s_hit;
  logic [IW-1:0] tlb_s_idx, tlb_r_idx;
  logic [18:0]   tlb_r_vppn;
  logic [9:0]    tlb_r_asid;
  logic [5:0]    tlb_r_ps;
  logic          tlb_r_e;
  logic [27:0]   tlb_r_elo0, tlb_r_elo1;
  logic          tlb_w_en;
  logic [IW-1:0] tlb_w_idx;
  logic [18:0]   tlb_w_vppn;
  logic [5:0]    tlb_w_ps;
  logic [9:0]    tlb_w_asid;
  logic          tlb_w_e;
  logic [27:0]   tlb_w_elo0, tlb_w_elo1;
  logic          tlb_inv_en;
  logic [4:0]    tlb_inv_op;
  logic [9:0]    tlb_inv_asid;
  logic [18:0]   tlb_inv_vppn;
  logic          resp_valid;
  logic [2:0]    resp_op;
  logic          resp_ine, resp_ne;
  logic [IW-1:0] resp_idx;
  logic [5:0]    resp_ps;
  logic [18:0]   resp_vppn;
  logic [9:0]    resp_asid;
  logic          resp_e;
  logic [27:0]   resp_elo0, resp_elo1;

  int nvec = 0;
  int nerr = 0;

  tlb_ctrl #(.TLBENTRY(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
    .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_vppn(csr_vppn),
    .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_refill(csr_refill),
    .tlb_s_vpn(tlb_s_vpn), .tlb_s_asid(tlb_s_asid), .tlb_s_hit(tlb_s_hit), .tlb_s_idx(tlb_s_idx),
    .tlb_r_idx(tlb_r_idx), .tlb_r_vppn(tlb_r_vppn), .tlb_r_asid(tlb_r_asid), .tlb_r_ps(tlb_r_ps),
    .tlb_r_e(tlb_r_e), .tlb_r_elo0(tlb_r_elo0), .tlb_r_elo1(tlb_r_elo1),
    .tlb_w_en(tlb_w_en), .tlb_w_idx(tlb_w_idx), .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps),
    .tlb_w_asid(tlb_w_asid), .tlb_w_e(tlb_w_e), .tlb_w_elo0(tlb_w_elo0), .tlb_w_elo1(tlb_w_elo1),
    .tlb_inv_en(tlb_inv_en), .tlb_inv_op(tlb_inv_op), .tlb_inv_asid(tlb_inv_asid),
    .tlb_inv_vppn(tlb_inv_vppn),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_ine(resp_ine), .resp_ne(resp_ne),
    .resp_idx(resp_idx), .resp_ps(resp_ps), .resp_vppn(resp_vppn), .resp_asid(resp_asid),
    .resp_e(resp_e), .resp_elo0(resp_elo0), .resp_elo1(resp_elo1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request in IDLE; returns #1 into the EXEC cycle.
  task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [31:0] va);
    req_valid    = 1'b1;
    req_op       = op;
    req_inv_op   = iop;
    req_inv_asid = 10'h155;
    req_inv_va   = va;
    step();
    req_valid    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0; req_inv_asid = '0;
    req_inv_va = '0; csr_idx = '0; csr_ps = '0; csr_ne = 1'b0; csr_vppn = '0;
    csr_asid = '0; csr_elo0 = '0; csr_elo1 = '0; csr_refill = 1'b0;
    tlb_s_hit = 1'b0; tlb_s_idx = '0; tlb_r_vppn = '0; tlb_r_asid = '0; tlb_r_ps = '0;
    tlb_r_e = 1'b0; tlb_r_elo0 = '0; tlb_r_elo1 = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_w_en", tlb_w_en, 0);
    chk("rst_inv_en", tlb_inv_en, 0);
    chk("rst_resp_idx", resp_idx, 0);
    step();

    // WR
    csr_idx = 4'd5; csr_vppn = 19'h12345; csr_ne = 1'b0; csr_ps = 6'd12; csr_asid = 10'h3A;
    issue(3'd2, 5'd0, 32'h0);
    chk("wr_w_en", tlb_w_en, 1);
    chk("wr_w_idx", tlb_w_idx, 5);
    chk("wr_w_e", tlb_w_e, 1);
    chk("wr_w_vppn", tlb_w_vppn, 19'h12345);
    chk("wr_ready_exec", req_ready, 0);
    chk("wr_rv_exec", resp_valid, 0);
    step();
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_resp_op", resp_op, 2);
    chk("wr_w_en_resp", tlb_w_en, 0);
    chk("wr_ready_resp", req_ready, 0);
    step();
    chk("wr_rv_idle", resp_valid, 0);
    chk("wr_ready_idle", req_ready, 1);

    // 17 FILLs: pointer walks 0..15 then wraps to 0
    csr_idx = 4'd7;
    for (int i = 0; i < 17; i++) begin
      issue(3'd3, 5'd0, 32'h0);
      chk("fill_w_en", tlb_w_en, 1);
      chk("fill_w_idx", tlb_w_idx, i % 16);
      step(); step();
    end
    csr_ne = 1'b1; csr_refill = 1'b1;
    issue(3'd3, 5'd0, 32'h0);
    chk("fill_w_e_refill", tlb_w_e, 1);
    chk("fill_w_idx_1", tlb_w_idx, 1);
    step(); step();
    csr_refill = 1'b0;
    issue(3'd3, 5'd0, 32'h0);
    chk("fill_w_e_ne", tlb_w_e, 0);
    step(); step();
    csr_ne = 1'b0;

    // SRCH hit / miss
    tlb_s_hit = 1'b1; tlb_s_idx = 4'd9; csr_vppn = 19'h0ABCD;
    issue(3'd0, 5'd0, 32'h0);
    chk("srch_vpn", tlb_s_vpn, 20'h1579A);
    chk("srch_no_strobe", {tlb_w_en, tlb_inv_en}, 0);
    step();
    chk("srch_hit_ne", resp_ne, 0);
    chk("srch_hit_idx", resp_idx, 9);
    step();
    tlb_s_hit = 1'b0; csr_idx = 4'd3;
    issue(3'd0, 5'd0, 32'h0);
    step();
    chk("srch_miss_ne", resp_ne, 1);
    chk("srch_miss_idx", resp_idx, 3);
    step();

    // RD invalid entry then valid entry
    csr_idx = 4'd4; tlb_r_e = 1'b0; tlb_r_ps = 6'd21; tlb_r_vppn = 19'h1ABCD;
    tlb_r_asid = 10'h2F; tlb_r_elo0 = 28'h1234567; tlb_r_elo1 = 28'h7654321;
    issue(3'd1, 5'd0, 32'h0);
    chk("rd_r_idx", tlb_r_idx, 4);
    step();
    chk("rd_inv_ne", resp_ne, 1);
    chk("rd_inv_data", {resp_ps, resp_vppn, resp_asid, resp_elo0, resp_elo1, resp_e}, 0);
    step();
    tlb_r_e = 1'b1;
    issue(3'd1, 5'd0, 32'h0);
    step();
    chk("rd_ne", resp_ne, 0);
    chk("rd_ps", resp_ps, 21);
    chk("rd_vppn", resp_vppn, 19'h1ABCD);
    chk("rd_elo1", resp_elo1, 28'h7654321);
    step();

    // INVTLB legal / reserved op
    issue(3'd4, 5'd5, 32'hABCDE000);
    chk("inv_en", tlb_inv_en, 1);
    chk("inv_vppn", tlb_inv_vppn, 19'h55E6F);
    chk("inv_op", tlb_inv_op, 5);
    chk("inv_asid", tlb_inv_asid, 10'h155);
    step();
    chk("inv_en_off", tlb_inv_en, 0);
    chk("inv_ine", resp_ine, 0);
    step();
    issue(3'd4, 5'd7, 32'hABCDE000);
    chk("inv7_en", tlb_inv_en, 0);
    step();
    chk("inv7_ine", resp_ine, 1);
    step();

    // Reserved request op
    issue(3'd6, 5'd0, 32'h0);
    chk("rsv_no_strobe", {tlb_w_en, tlb_inv_en}, 0);
    step();
    chk("rsv_ine", resp_ine, 1);
    chk("rsv_op", resp_op, 6);
    step();

    // Request held through RESP is accepted on the following IDLE cycle
    req_valid = 1'b1; req_op = 3'd2;
    step();
    chk("hold_exec_w_en", tlb_w_en, 1);
    step();
    chk("hold_resp_ready", req_ready, 0);
    step();
    chk("hold_idle_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("hold_second_exec", tlb_w_en, 1);
    step(); step();

    // Reset in EXEC of a WR
    issue(3'd2, 5'd0, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_exec_w_en", tlb_w_en, 0);
    step();
    reset = 1'b0;
    chk("rst_exec_ready", req_ready, 1);
    chk("rst_exec_rv", resp_valid, 0);
    step();
    chk("rst_exec_rv2", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
